// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receive byte FIFO (first-word-fall-through) with level,
//            watermark, sticky overflow and character-timeout status.
//            Optional statistics counters: define UART_RX_FIFO_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          flush,
    input  logic [AW:0]   watermark,
    input  logic [31:0]   timeout_cycles,
    input  logic          overflow_clr,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          irq_watermark,
    output logic          irq_timeout
`ifdef UART_RX_FIFO_STATS_EN
    ,
    output logic [15:0]   push_cnt,
    output logic [15:0]   drop_cnt
`endif
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_overflow;
    logic          r_irq_wm;
    logic          r_irq_to;
    logic [31:0]   r_to_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_push_acc;
    logic          w_pop_acc;
    logic          w_drop;
    logic          w_to_hit;

    // Handshake flags come only from the registered level, never from the
    // opposite side's request, so a full FIFO cannot accept a push even
    // when a pop happens in the same cycle.
    assign w_full     = (r_level == c_DEPTH);
    assign w_empty    = (r_level == '0);
    assign w_push     = in_valid & ~w_full;
    assign w_pop      = out_ready & ~w_empty;
    assign w_push_acc = w_push & ~flush;
    assign w_pop_acc  = w_pop & ~flush;
    assign w_drop     = in_valid & w_full;
    assign w_to_hit   = (timeout_cycles != 32'd0) && !w_empty &&
                        (r_to_cnt == (timeout_cycles - 32'd1));

    assign in_ready      = ~w_full;
    assign out_valid     = ~w_empty;
    assign out_data      = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign level         = r_level;
    assign full          = w_full;
    assign empty         = w_empty;
    assign overflow      = r_overflow;
    assign irq_watermark = r_irq_wm;
    assign irq_timeout   = r_irq_to & (timeout_cycles != 32'd0);

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Set beats clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_wm <= 1'b0;
        end else begin
            r_irq_wm <= (watermark != '0) && (r_level >= watermark);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (flush || w_push || w_pop || w_empty) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    // The counter passes timeout_cycles-1 only once per idle stretch, so
    // the interrupt cannot re-fire until activity has cleared the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_to <= 1'b0;
        end else if (flush || w_push || w_pop || (timeout_cycles == 32'd0)) begin
            r_irq_to <= 1'b0;
        end else if (w_to_hit) begin
            r_irq_to <= 1'b1;
        end
    end

`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0] r_push_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push_acc) begin
                r_push_cnt <= r_push_cnt + 16'd1;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign push_cnt = r_push_cnt;
    assign drop_cnt = r_drop_cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire
